// File: rtl/uart_fifo_core_if.sv
// Host-side bundle of the UART core: configuration, TX/RX FIFO handshakes,
// sticky error flags and the serial pins.
interface uart_fifo_core_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 parity_en;
  logic                 parity_odd;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_write;
  logic                 tx_full;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_read;
  logic                 rx_overrun;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 err_clear;
  logic                 uart_rx;
  logic                 uart_tx;

  modport master (
    output baud_div, parity_en, parity_odd, tx_data, tx_write, rx_read, err_clear, uart_rx,
    input  tx_full, tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err, uart_tx
  );

  modport slave (
    input  baud_div, parity_en, parity_odd, tx_data, tx_write, rx_read, err_clear, uart_rx,
    output tx_full, tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err, uart_tx
  );
endinterface

// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver, each behind a FIFO_DEPTH-entry FIFO, with
// optional parity, a runtime baud divisor and sticky receive error flags.
module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_fifo_core_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DIV_WIDTH-1:0] w_div;
  assign w_div = (bus.baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : bus.baud_div;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_tx_wr, r_tx_rd;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic                 w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = bus.tx_write & ~w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rd];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_W'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_W'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_W'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t               r_tx_state, w_tx_next;
  logic [DIV_WIDTH-1:0] r_tx_div, r_tx_baud;
  logic [IDX_W-1:0]     r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par_en, r_tx_par_bit;
  logic                 w_tx_bit_end, w_tx_line;

  assign w_tx_bit_end = (r_tx_baud == r_tx_div - DIV_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE: if (!w_tx_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_next = S_START;
      end
      S_START:  if (w_tx_bit_end) w_tx_next = S_DATA;
      S_DATA:   if (w_tx_bit_end && r_tx_idx == LAST_IDX)
                  w_tx_next = r_tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_bit_end) w_tx_next = S_STOP;
      S_STOP: if (w_tx_bit_end) begin
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (!w_tx_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_next = S_START;
        end else begin
          w_tx_next = S_IDLE;
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_div    <= DIV_WIDTH'(4);
      r_tx_baud   <= '0;
      r_tx_idx    <= '0;
      r_tx_par_en <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_div    <= w_div;
      r_tx_baud   <= '0;
      r_tx_idx    <= '0;
      r_tx_par_en <= bus.parity_en;
    end else if (r_tx_state != S_IDLE) begin
      if (w_tx_bit_end) begin
        r_tx_baud <= '0;
        if (r_tx_state == S_DATA) r_tx_idx <= r_tx_idx + IDX_W'(1);
      end else begin
        r_tx_baud <= r_tx_baud + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_pop) begin
      r_tx_shift   <= w_tx_head;
      r_tx_par_bit <= (^w_tx_head) ^ bus.parity_odd;
    end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
      r_tx_shift   <= r_tx_shift >> 1;
    end
  end

  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_START:  w_tx_line = 1'b0;
      S_DATA:   w_tx_line = r_tx_shift[0];
      S_PARITY: w_tx_line = r_tx_par_bit;
      default:  w_tx_line = 1'b1;
    endcase
  end

  assign bus.uart_tx = w_tx_line;
  assign bus.tx_full = w_tx_full;
  assign bus.tx_busy = (r_tx_state != S_IDLE) | ~w_tx_empty;

  // ---------------------------------------------------------------- RX sync + FSM
  logic                 r_rx_s1, r_rx_s2, w_rx;
  state_t               r_rx_state, w_rx_next;
  logic [DIV_WIDTH-1:0] r_rx_div, r_rx_baud, w_rx_half;
  logic [IDX_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_en, r_rx_par_odd, r_rx_par_bit;
  logic                 w_rx_mid, w_rx_bit_end, w_rx_stop_smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end
  assign w_rx = r_rx_s2;

  assign w_rx_half    = r_rx_div >> 1;
  assign w_rx_mid     = (r_rx_baud == w_rx_half - DIV_WIDTH'(1));
  assign w_rx_bit_end = (r_rx_baud == r_rx_div - DIV_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_stop_smp = 1'b0;
    case (r_rx_state)
      S_IDLE:   if (!w_rx) w_rx_next = S_START;
      S_START:  if (w_rx_mid) w_rx_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_bit_end && r_rx_idx == LAST_IDX)
                  w_rx_next = r_rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_bit_end) w_rx_next = S_STOP;
      S_STOP: if (w_rx_bit_end) begin
        w_rx_stop_smp = 1'b1;
        w_rx_next     = S_IDLE;
      end
      default: w_rx_next = S_IDLE;
    endcase
  end

  // Counter restarts at the start mid-point so later samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_div     <= DIV_WIDTH'(4);
      r_rx_baud    <= '0;
      r_rx_idx     <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_div     <= w_div;
          r_rx_baud    <= '0;
          r_rx_idx     <= '0;
          r_rx_par_en  <= bus.parity_en;
          r_rx_par_odd <= bus.parity_odd;
        end
        S_START: r_rx_baud <= w_rx_mid ? '0 : r_rx_baud + DIV_WIDTH'(1);
        default: begin
          if (w_rx_bit_end) begin
            r_rx_baud <= '0;
            if (r_rx_state == S_DATA) r_rx_idx <= r_rx_idx + IDX_W'(1);
          end else begin
            r_rx_baud <= r_rx_baud + DIV_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_bit_end && r_rx_state == S_DATA)   r_rx_shift   <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
    if (w_rx_bit_end && r_rx_state == S_PARITY) r_rx_par_bit <= w_rx;
  end

  // ---------------------------------------------------------------- RX FIFO + flags
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_rx_wr, r_rx_rd;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic                 w_rx_full, w_rx_empty, w_rx_push, w_rx_wr, w_rx_pop;
  logic                 w_rx_ovr, w_rx_ferr, w_rx_perr;
  logic                 r_rx_overrun, r_rx_frame_err, r_rx_parity_err;

  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_pop   = bus.rx_read & ~w_rx_empty;
  assign w_rx_push  = w_rx_stop_smp & w_rx;
  assign w_rx_wr    = w_rx_push & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr   = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_rx_ferr  = w_rx_stop_smp & ~w_rx;
  assign w_rx_perr  = w_rx_push & r_rx_par_en &
                      (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr] <= r_rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr         <= '0;
      r_rx_rd         <= '0;
      r_rx_cnt        <= '0;
      r_rx_overrun    <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_parity_err <= 1'b0;
    end else begin
      if (w_rx_wr)  r_rx_wr <= r_rx_wr + PTR_W'(1);
      if (w_rx_pop) r_rx_rd <= r_rx_rd + PTR_W'(1);
      case ({w_rx_wr, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_W'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      // A flag event in the same cycle as err_clear keeps the flag set.
      if (w_rx_ovr)            r_rx_overrun    <= 1'b1;
      else if (bus.err_clear)  r_rx_overrun    <= 1'b0;
      if (w_rx_ferr)           r_rx_frame_err  <= 1'b1;
      else if (bus.err_clear)  r_rx_frame_err  <= 1'b0;
      if (w_rx_perr)           r_rx_parity_err <= 1'b1;
      else if (bus.err_clear)  r_rx_parity_err <= 1'b0;
    end
  end

  assign bus.rx_valid      = ~w_rx_empty;
  assign bus.rx_data       = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
  assign bus.rx_overrun    = r_rx_overrun;
  assign bus.rx_frame_err  = r_rx_frame_err;
  assign bus.rx_parity_err = r_rx_parity_err;
endmodule
